// File: rtl/crossbar_control_issuer_pkg.sv
// Shared types and helpers for the crossbar control issuer: FSM states,
// select-field widths and control-word packing.
package crossbar_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    XFER
  } state_t;

  localparam int unsigned MAX_CBW = 256;

  // A single-entry side still needs one select bit on the wire.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // input_sel sits at the top of the word, output_sel right below it, rest zero.
  function automatic logic [MAX_CBW-1:0] pack_control(
    input int unsigned cbw,
    input int unsigned isw,
    input int unsigned osw,
    input logic [31:0] in_sel,
    input logic [31:0] out_sel
  );
    logic [MAX_CBW-1:0] word;
    word = MAX_CBW'(in_sel) << (cbw - isw);
    word = word | (MAX_CBW'(out_sel) << (cbw - isw - osw));
    return word;
  endfunction

endpackage

// File: rtl/crossbar_control_issuer_fifo.sv
// Route request queue: val/rdy push side, pop/empty read side, pointer
// wrap modulo DEPTH with an explicit full flag.
module route_req_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] push_msg,
  input  logic             push_val,
  output logic             push_rdy,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_msg,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             push;
  logic             do_pop;

  // Not ready while reset is held so nothing is queued during reset.
  assign push_rdy = !full && !reset;
  assign push     = push_val && push_rdy;
  assign empty    = (wr_ptr == rd_ptr) && !full;
  assign do_pop   = pop && !empty;
  assign pop_msg  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_msg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !do_pop && ((wr_ptr + AW'(1)) == rd_ptr)) full <= 1'b1;
      else if (do_pop && !push)                             full <= 1'b0;
    end
  end

endmodule

// File: rtl/crossbar_control_issuer.sv
// Crossbar control initiator: queues route requests, issues each as a packed
// control word and holds off the next one until its payload beats complete.
module crossbar_control_issuer
  import crossbar_ctrl_pkg::*;
#(
  parameter int unsigned N_INPUTS          = 2,
  parameter int unsigned N_OUTPUTS         = 2,
  parameter int unsigned CONTROL_BIT_WIDTH = 42,
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter int unsigned BEAT_WIDTH        = 8
) (
  input  logic                                                           clk,
  input  logic                                                           reset,
  input  logic [sel_width(N_INPUTS)+sel_width(N_OUTPUTS)+BEAT_WIDTH-1:0] req_msg,
  input  logic                                                           req_val,
  output logic                                                           req_rdy,
  output logic [CONTROL_BIT_WIDTH-1:0]                                   control,
  output logic                                                           control_val,
  input  logic                                                           control_rdy,
  input  logic                                                           xfer_fire,
  output logic                                                           busy,
  output logic [BEAT_WIDTH-1:0]                                          beats_left,
  output logic                                                           err
);

  localparam int unsigned ISW = sel_width(N_INPUTS);
  localparam int unsigned OSW = sel_width(N_OUTPUTS);
  localparam int unsigned MW  = ISW + OSW + BEAT_WIDTH;

  state_t                       state, state_d;
  logic [BEAT_WIDTH-1:0]        cur_beats, cur_beats_d;
  logic [CONTROL_BIT_WIDTH-1:0] control_d;
  logic                         control_val_d;
  logic [BEAT_WIDTH-1:0]        beats_left_d;
  logic                         err_d;

  logic [MW-1:0]         head;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic [ISW-1:0]        head_in;
  logic [OSW-1:0]        head_out;
  logic [BEAT_WIDTH-1:0] head_beats;
  logic                  head_ok;

  route_req_fifo #(
    .WIDTH (MW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_msg (req_msg),
    .push_val (req_val),
    .push_rdy (req_rdy),
    .pop      (fifo_pop),
    .pop_msg  (head),
    .empty    (fifo_empty)
  );

  assign {head_in, head_out, head_beats} = head;
  assign head_ok = (32'(head_in) < N_INPUTS) && (32'(head_out) < N_OUTPUTS);
  assign busy    = (state != IDLE);

  always_comb begin
    state_d       = state;
    cur_beats_d   = cur_beats;
    control_d     = control;
    control_val_d = control_val;
    beats_left_d  = beats_left;
    err_d         = err;
    fifo_pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (!head_ok) begin
            err_d = 1'b1;
          end else begin
            state_d       = ISSUE;
            cur_beats_d   = head_beats;
            control_val_d = 1'b1;
            control_d     = CONTROL_BIT_WIDTH'(pack_control(CONTROL_BIT_WIDTH, ISW, OSW,
                                                            32'(head_in), 32'(head_out)));
          end
        end
      end
      ISSUE: begin
        // A zero-beat route only configures the crossbar; no payload to wait for.
        if (control_rdy) begin
          control_val_d = 1'b0;
          if (cur_beats == '0) begin
            state_d = IDLE;
          end else begin
            beats_left_d = cur_beats;
            state_d      = XFER;
          end
        end
      end
      XFER: begin
        if (xfer_fire && (beats_left != '0)) begin
          beats_left_d = beats_left - BEAT_WIDTH'(1);
          if (beats_left == BEAT_WIDTH'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cur_beats   <= '0;
      control     <= '0;
      control_val <= 1'b0;
      beats_left  <= '0;
      err         <= 1'b0;
    end else begin
      state       <= state_d;
      cur_beats   <= cur_beats_d;
      control     <= control_d;
      control_val <= control_val_d;
      beats_left  <= beats_left_d;
      err         <= err_d;
    end
  end

endmodule

// File: tb/tb_crossbar_control_issuer.sv
// Scoreboard bench for crossbar_control_issuer: accepted requests are queued
// with their acceptance cycle; a monitor derives expected per-cycle outputs.
module tb_crossbar_control_issuer;

  localparam int unsigned NI    = 3;
  localparam int unsigned NO    = 3;
  localparam int unsigned CBW   = 42;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BW    = 8;
  localparam int unsigned ISW   = $clog2(NI);
  localparam int unsigned OSW   = $clog2(NO);

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [ISW+OSW+BW-1:0] req_msg = '0;
  logic                  req_val = 1'b0;
  logic                  req_rdy;
  logic [CBW-1:0]        control;
  logic                  control_val;
  logic                  control_rdy = 1'b0;
  logic                  xfer_fire = 1'b0;
  logic                  busy;
  logic [BW-1:0]         beats_left;
  logic                  err;

  crossbar_control_issuer #(
    .N_INPUTS          (NI),
    .N_OUTPUTS         (NO),
    .CONTROL_BIT_WIDTH (CBW),
    .FIFO_DEPTH        (DEPTH),
    .BEAT_WIDTH        (BW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_msg     (req_msg),
    .req_val     (req_val),
    .req_rdy     (req_rdy),
    .control     (control),
    .control_val (control_val),
    .control_rdy (control_rdy),
    .xfer_fire   (xfer_fire),
    .busy        (busy),
    .beats_left  (beats_left),
    .err         (err)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    bit          ok;
    logic [CBW-1:0] word;
    int          beats;
    int          acc;
  } ent_t;

  ent_t q[$];
  ent_t cur;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   free_cyc = 0;
  int   exp_left = 0;
  bit   inflight = 0;
  bit   in_xfer = 0;
  bit   err_exp = 0;
  int   rdy_mode = 0;
  bit   fire_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Handshake-side driver: control_rdy and xfer_fire change just after each edge.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       control_rdy = 1'b0;
      1:       control_rdy = 1'b1;
      default: control_rdy = ($urandom_range(0, 3) != 0);
    endcase
    xfer_fire = fire_mode && ($urandom_range(0, 1) == 1);
  end

  // Monitor: entries leave the queue one per free IDLE cycle, a valid route
  // shows control_val the cycle after its pop, completion frees the next cycle.
  initial forever begin
    int c;
    int p;
    int occ;
    @(negedge clk);
    if (!reset) begin
      c = cyc;
      while (!inflight && q.size() != 0) begin
        p = (free_cyc > q[0].acc + 1) ? free_cyc : q[0].acc + 1;
        if (p >= c) break;
        cur = q.pop_front();
        if (!cur.ok) begin
          err_exp  = 1'b1;
          free_cyc = p + 1;
        end else begin
          inflight = 1'b1;
          in_xfer  = 1'b0;
        end
      end
      occ = 0;
      foreach (q[i]) if (q[i].acc < c) occ++;
      check("req_rdy", 64'(req_rdy), 64'(occ < int'(DEPTH)));
      check("control_val", 64'(control_val), 64'(inflight && !in_xfer));
      if (inflight && !in_xfer) check("control", 64'(control), 64'(cur.word));
      check("busy", 64'(busy), 64'(inflight));
      check("beats_left", 64'(beats_left), 64'(exp_left));
      check("err", 64'(err), 64'(err_exp));
      if (inflight && in_xfer) begin
        if (xfer_fire) begin
          exp_left--;
          if (exp_left == 0) begin
            inflight = 1'b0;
            in_xfer  = 1'b0;
            free_cyc = c + 1;
          end
        end
      end else if (inflight && control_rdy) begin
        if (cur.beats == 0) begin
          inflight = 1'b0;
          free_cyc = c + 1;
        end else begin
          in_xfer  = 1'b1;
          exp_left = cur.beats;
        end
      end
    end
  end

  task automatic send_req(input int in_s, input int out_s, input int b, input int bound,
                          output bit ok);
    ent_t e;
    req_msg = {ISW'(in_s), OSW'(out_s), BW'(b)};
    req_val = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (req_rdy) begin
        ok       = 1'b1;
        e.ok     = (in_s < int'(NI)) && (out_s < int'(NO));
        e.word   = '0;
        e.word[CBW-1 -: ISW]     = ISW'(in_s);
        e.word[CBW-ISW-1 -: OSW] = OSW'(out_s);
        e.beats  = b;
        e.acc    = cyc;
        q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    req_val = 1'b0;
  endtask

  task automatic push_must(input int in_s, input int out_s, input int b);
    bit ok;
    send_req(in_s, out_s, b, 300, ok);
    check("accept", 64'(ok), 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || inflight) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("drain_done", 64'(n < 2000), 64'd1);
    idle_cycles(4);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_control"}, 64'(control), 64'd0);
    check({tag, "_control_val"}, 64'(control_val), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_beats_left"}, 64'(beats_left), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_req_rdy"}, 64'(req_rdy), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n_acc;
    int n;

    #1 reset = 1'b1;
    #2 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle_cycles(2);

    // Single route, control held off for a few cycles, then three beats.
    rdy_mode = 0; fire_mode = 0;
    push_must(1, 0, 3);
    idle_cycles(5);
    rdy_mode = 1; fire_mode = 1;
    drain();

    // Stalled control: one entry in ISSUE plus a full queue, sixth stalls.
    rdy_mode = 0; fire_mode = 0;
    n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      send_req(k % 3, (k + 1) % 3, (k % 3) + 1, 6, ok);
      if (ok) n_acc++;
    end
    check("stall_accepts", 64'(n_acc), 64'd5);
    rdy_mode = 2; fire_mode = 1;
    drain();

    // Zero-beat routes followed by a normal one.
    rdy_mode = 1; fire_mode = 1;
    push_must(2, 1, 0);
    push_must(0, 2, 0);
    push_must(1, 1, 2);
    drain();

    // Out-of-range selects are dropped and err sticks.
    push_must(3, 0, 2);
    push_must(0, 3, 1);
    push_must(2, 2, 1);
    drain();

    // Random traffic with random control_rdy and xfer_fire.
    rdy_mode = 2; fire_mode = 1;
    for (int k = 0; k < 60; k++) begin
      push_must($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4));
      idle_cycles($urandom_range(0, 3));
    end
    drain();

    // Reset in the middle of a 5-beat transfer with two requests queued.
    rdy_mode = 1; fire_mode = 0;
    push_must(1, 2, 5);
    push_must(0, 0, 2);
    push_must(2, 0, 1);
    n = 0;
    while (!in_xfer && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_xfer", 64'(in_xfer), 64'd1);
    @(posedge clk);
    #3 reset = 1'b1;
    q.delete();
    inflight = 1'b0; in_xfer = 1'b0; exp_left = 0; err_exp = 1'b0; free_cyc = 0;
    #1 check_reset_outputs("midxfer_reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle_cycles(10);
    fire_mode = 1;
    push_must(2, 2, 2);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
